// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the multi-requester UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] DEFAULT_EOL    = 8'h0A;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: latches one byte on valid & ready, then drives start, LSB-first data, stop.
module uart_tx_ser
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      ser_tx,
  output logic                      busy
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  ser_state_t                state, state_nx;
  logic [BW-1:0]             baud, baud_nx;
  logic [2:0]                bit_idx, bit_nx;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nx;
  logic                      tx_nx;
  logic                      baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign ready     = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    case (state)
      S_IDLE: begin
        if (valid) begin
          state_nx = S_START;
          baud_nx  = '0;
          shreg_nx = data;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_nx = S_DATA;
          baud_nx  = '0;
          bit_nx   = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nx  = '0;
          bit_nx   = bit_idx + 3'd1;
          shreg_nx = {1'b0, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          state_nx = S_IDLE;
          baud_nx  = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Line level is registered from the next state so ser_tx never glitches.
    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ser_tx  <= 1'b1;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
      ser_tx  <= tx_nx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin lock arbiter sharing one UART line; a grant is held until EOL or idle timeout.
// state  | meaning
// IDLE   | no lock held; round-robin pick among valid requesters
// LOCKED | grant_id owns the serializer until EOL accept or timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         LOCK_TIMEOUT = 1024,
  parameter logic [7:0] EOL_CHAR     = DEFAULT_EOL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_tx,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int            IW      = $clog2(NUM_REQ);
  localparam int            TW      = $clog2(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);

  arb_state_t                state, state_nx;
  logic [IW-1:0]             ptr, ptr_nx;
  logic [IW-1:0]             gid, gid_nx;
  logic [TW-1:0]             to_cnt, to_nx;
  logic [IW-1:0]             winner, idx;
  logic                      any_req;
  logic                      sel_valid;
  logic [UART_DATA_BITS-1:0] sel_data;
  logic                      locked;
  logic                      ser_valid, ser_ready;
  logic                      accept;

  assign locked      = (state == LOCKED);
  assign ser_valid   = locked & sel_valid;
  assign accept      = ser_valid & ser_ready;
  assign grant_valid = locked;
  assign grant_id    = gid;

  // Search upward from ptr+1 with wrap; the first hit wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid == IW'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[i*8 +: 8];
        req_ready[i] = locked & ser_ready;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gid_nx   = gid;
    to_nx    = to_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = LOCKED;
          gid_nx   = winner;
          to_nx    = '0;
        end
      end
      LOCKED: begin
        if (accept) to_nx = '0;
        else if (!sel_valid && (to_cnt != TO_LAST)) to_nx = to_cnt + 1'b1;
        // The EOL byte itself still goes out; only the lock is dropped.
        if ((accept && (sel_data == EOL_CHAR)) || (to_cnt == TO_LAST)) begin
          state_nx = IDLE;
          ptr_nx   = gid;
          to_nx    = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NUM_REQ - 1);
      gid    <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      gid    <= gid_nx;
      to_cnt <= to_nx;
    end
  end

  uart_tx_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .data  (sel_data),
    .valid (ser_valid),
    .ready (ser_ready),
    .ser_tx(ser_tx),
    .busy  (busy)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART line decoder and expected-byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int         NR  = 4;
  localparam int         CPB = 4;
  localparam int         LT  = 16;
  localparam logic [7:0] EOL = 8'h0A;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            ser_tx;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .CLKS_PER_BIT(CPB),
    .LOCK_TIMEOUT(LT),
    .EOL_CHAR    (EOL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ser_tx     (ser_tx),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct {
    int id;
    int data;
    int cyc;
  } acc_t;

  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  acc_t       acc_q[$];
  int         gnt_q[$];
  int         gfall_q[$];
  int         busy_q[$];
  int         busy_run = 0;
  int         first_rdy1 = -1;
  bit         prev_gv = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] feed_q[NR][$];
  bit         mon_busy = 1'b0;
  int         mk = 0;
  logic [7:0] rx = '0;
  logic       start_s = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event logger: accepts, grant edges, busy run lengths (sampled on the falling edge).
  always @(negedge clk) begin
    if (rst) begin
      prev_gv  = 1'b0;
      busy_run = 0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) acc_q.push_back('{i, int'(req_data[i*8 +: 8]), cyc});
      if (grant_valid && !prev_gv) gnt_q.push_back(int'(grant_id));
      if (!grant_valid && prev_gv) gfall_q.push_back(cyc);
      if (req_ready[1] && first_rdy1 < 0) first_rdy1 = cyc;
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        busy_q.push_back(busy_run);
        busy_run = 0;
      end
      prev_gv = grant_valid;
    end
  end

  // Line decoder: samples mid-bit, compares each byte against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (ser_tx === 1'b0) begin
        mon_busy = 1'b1;
        mk = 0;
      end
    end else begin
      mk++;
      if (mk == CPB / 2) start_s = ser_tx;
      for (int j = 0; j < 8; j++)
        if (mk == CPB / 2 + CPB * (j + 1)) rx[j] = ser_tx;
      if (mk == CPB / 2 + 9 * CPB) begin
        chk("start_bit", start_s, 0);
        chk("stop_bit", ser_tx, 1);
        if (exp_q.size() != 0) chk("rx_byte", rx, exp_q.pop_front());
        else chk("rx_byte_unexpected", rx, 32'hxxxxxxxx);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    acc_q.delete();
    gnt_q.delete();
    gfall_q.delete();
    busy_q.delete();
    first_rdy1 = -1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  function automatic bit feed_empty();
    for (int i = 0; i < NR; i++)
      if (feed_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Presents each requester's queued bytes, popping on accept.
  task automatic feed(input int budget);
    int n = 0;
    bit acc[NR];
    while (n < budget && !feed_empty()) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (feed_q[i].size() != 0);
        if (feed_q[i].size() != 0) req_data[i*8 +: 8] = feed_q[i][0];
      end
      @(negedge clk);
      for (int i = 0; i < NR; i++) acc[i] = req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (acc[i]) void'(feed_q[i].pop_front());
      n++;
    end
    req_valid = '0;
    chk("feed_done", feed_empty(), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && (exp_q.size() != 0 || busy || grant_valid || mon_busy)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", (exp_q.size() == 0) && !busy && !grant_valid && !mon_busy, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int exp_g[5] = '{0, 1, 2, 3, 0};
    bit got;

    // Basic frame and EOL release
    do_reset();
    feed_q[0] = '{8'h55, EOL};
    exp_q.push_back(8'h55);
    exp_q.push_back(EOL);
    feed(300);
    drain(400);
    chk("t1_nacc", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("t1_spacing", acc_q[1].cyc - acc_q[0].cyc, 1 + 10 * CPB);
      chk("t1_gfall", qget(gfall_q, 0), acc_q[1].cyc + 1);
    end
    chk("t1_busy_len0", qget(busy_q, 0), 10 * CPB);
    chk("t1_busy_len1", qget(busy_q, 1), 10 * CPB);

    // No interleave between two line sources
    do_reset();
    feed_q[0] = '{8'h41, 8'h42, EOL};
    feed_q[1] = '{8'h43, EOL};
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(EOL);
    exp_q.push_back(8'h43);
    exp_q.push_back(EOL);
    feed(600);
    drain(400);
    chk("t2_nacc", acc_q.size(), 5);
    for (int i = 0; i < acc_q.size() && i < 5; i++) chk("t2_order", acc_q[i].id, (i < 3) ? 0 : 1);
    if (acc_q.size() >= 3) chk("t2_rdy1_after_eol", first_rdy1 > acc_q[2].cyc, 1);

    // Round robin
    do_reset();
    feed_q[0] = '{EOL, EOL};
    for (int i = 1; i < NR; i++) feed_q[i] = '{EOL};
    repeat (5) exp_q.push_back(EOL);
    feed(800);
    drain(400);
    chk("t3_ngrants", gnt_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_grant_seq", qget(gnt_q, i), exp_g[i]);

    // Idle timeout releases the lock
    do_reset();
    feed_q[2] = '{8'h58};
    feed_q[3] = '{8'h59, EOL};
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h59);
    exp_q.push_back(EOL);
    feed(600);
    drain(400);
    chk("t4_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t4_first_id", acc_q[0].id, 2);
      chk("t4_second_id", acc_q[1].id, 3);
      chk("t4_release", qget(gfall_q, 0), acc_q[0].cyc + LT + 1);
      chk("t4_next_start", acc_q[1].cyc, acc_q[0].cyc + 1 + 10 * CPB);
    end
    chk("t4_grant1", qget(gnt_q, 1), 3);

    // Reset mid-frame
    do_reset();
    req_valid[0]     = 1'b1;
    req_data[7:0]    = 8'hA5;
    got              = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = req_ready[0];
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    chk("t5_accept", got, 1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("t5_bit3", ser_tx, 0);
    chk("t5_busy_before", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_ser_tx", ser_tx, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_gv", grant_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    feed_q[1] = '{EOL};
    exp_q.push_back(EOL);
    feed(300);
    drain(400);
    chk("t5_grant", qget(gnt_q, 0), 1);

    // Back-to-back frames
    do_reset();
    feed_q[0] = '{8'h31, 8'h32, 8'h33};
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    feed(400);
    drain(400);
    chk("t6_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t6_gap1", acc_q[1].cyc - acc_q[0].cyc, 1 + 10 * CPB);
      chk("t6_gap2", acc_q[2].cyc - acc_q[1].cyc, 1 + 10 * CPB);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmit line between NUM_REQ byte-stream requesters, e.g. firmware log sources feeding the testbench UART monitor.
- Grants one requester at a time and holds the grant until that requester sends an end-of-line byte or goes idle past a timeout, so text lines never interleave on ser_tx.
- Contains the baud-timed serializer that drives the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 16, clk cycles per UART bit (>=2).
- LOCK_TIMEOUT, 1024, idle cycles before a held grant is dropped (>=2).
- EOL_CHAR, 8'h0A, byte that releases the grant.

Ports:
- clk  in  1  system clock; the only clock. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  per-requester accept.
- ser_tx  out  1  UART line; idles high.
- grant_valid  out  1  a requester holds the lock.
- grant_id  out  $clog2(NUM_REQ)  index of the locked requester.
- busy  out  1  serializer is mid-frame.

Behaviour:
- Reset values (next edge with rst=1): ser_tx=1, req_ready=0, grant_valid=0, grant_id=0, busy=0, RR pointer=NUM_REQ-1, timeout counter=0. Reset mid-frame aborts the frame and drives ser_tx high immediately; no partial byte resumes.
- Arbiter FSM has two states, IDLE and LOCKED.
- IDLE:
  - If any req_valid is high, pick the first set index searching upward from pointer+1 (with wrap-around).
  - Next cycle: LOCKED, grant_valid=1, grant_id=winner.
  - One cycle of arbitration latency.
- LOCKED:
  - req_ready[grant_id] = serializer idle (busy=0 and not loading). All other req_ready bits are 0.
  - A byte is accepted on req_valid & req_ready in the same cycle.
  - Release (to IDLE next cycle, pointer<=grant_id, grant_valid=0) happens on either:
    - acceptance of a byte equal to EOL_CHAR (the EOL byte itself is still transmitted), or
    - the timeout counter reaching LOCK_TIMEOUT-1.
  - Timeout counter: +1 each LOCKED cycle in which req_valid[grant_id]=0. It clears on any accept and on entering LOCKED. It saturates; no wrap.
  - Release and a new grant never share a cycle. The next requester waits for IDLE arbitration and then for the serializer to finish the EOL frame.
- Serializer FSM has states S_IDLE, S_START, S_DATA, S_STOP.
  - Accept at edge T: busy=1 and ser_tx=0 from T+1 for CLKS_PER_BIT cycles.
  - Then 8 data bits, LSB first, CLKS_PER_BIT cycles each.
  - Then a stop bit (ser_tx=1) for CLKS_PER_BIT cycles.
  - busy falls, and req_ready may rise, at T+1+10*CLKS_PER_BIT. There is no inter-frame gap beyond the stop bit.
  - Bit counter is 3 bits and wraps at 7 into S_STOP. Baud counter counts 0..CLKS_PER_BIT-1.
- Simultaneous requests are resolved by round robin only. A requester dropping req_valid while locked is not an error: the grant is held until EOL or timeout.
- req_data of a non-granted requester is ignored. Only the accepted byte is latched, so later changes on req_data do not affect the frame in flight.

Decomposition:
- Package uart_arb_pkg:
  - arbiter state enum (IDLE, LOCKED);
  - serializer state enum (S_IDLE, S_START, S_DATA, S_STOP);
  - UART_DATA_BITS=8;
  - default EOL constant 8'h0A.
- Sub-module uart_tx_ser: byte in / valid-ready / ser_tx / busy, parameter CLKS_PER_BIT.
- The top holds the arbiter FSM, RR pointer, timeout counter and grant mux.

Test Plan:
- Basic frame: CLKS_PER_BIT=4; requester 0 sends 0x55 then 0x0A → ser_tx shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 clk each. busy high for exactly 40 cycles. grant_valid drops one cycle after 0x0A is accepted.
- No interleave: req0 holds "AB\n" and req1 holds "C\n", both valid at cycle 0 → decoded line order is 'A','B',0x0A,'C',0x0A. req_ready[1] stays 0 until req0's 0x0A is accepted.
- Round robin: all 4 requesters continuously send single 0x0A → grant_id sequence 0,1,2,3,0 with no requester skipped.
- Timeout: LOCK_TIMEOUT=16; req2 sends 'X' then deasserts req_valid → grant is released 16 cycles after the accept. req3, pending, is granted next, and its byte starts only after the 'X' frame ends.
- Reset mid-frame: assert rst during data bit 3 of 0xA5 → ser_tx=1, busy=0, grant_valid=0, all req_ready=0 on the next edge. After rst drops, a fresh 0x0A from req1 is framed correctly.
- Back-to-back: req0 keeps req_valid high for 0x31,0x32,0x33 → second accept happens exactly 1+10*CLKS_PER_BIT cycles after the first, with no idle bits between frames.
